operand_fetch: RTL and testbench

- Pipeline stage directly upstream of the 64-bit register file.
- Accepts decoded instructions on a valid/ready handshake and drives the file's two read-index ports.
- Captures the file's registered read data one cycle later, patches it with a writeback bypass, and presents complete operands to execute on a valid/ready handshake.
- Hides the file's one-cycle synchronous read and its read-old-on-same-edge-write behaviour from downstream.

---
 rtl/soc_pkg.sv | 29 ++
 rtl/operand_fetch_if.sv | 59 +++++
 rtl/opfetch_bypass.sv | 48 ++++
 rtl/operand_fetch.sv | 143 ++++++++++++++
 tb/tb_operand_fetch.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/soc_pkg.sv
// Shared SoC constants, register-index type and the fetch-stage instruction payload.
package soc_pkg;

    localparam int unsigned XLEN   = 64;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned CTRL_W = 16;
    localparam int unsigned PERF_W = 32;

    typedef logic [REG_AW-1:0] reg_idx_t;

    localparam reg_idx_t REG_ZERO = REG_AW'(0);

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   imm;
        logic [CTRL_W-1:0] ctrl;
        reg_idx_t          rd;
        reg_idx_t          rs1;
        reg_idx_t          rs2;
    } fetch_instr_t;

    // A writeback collides with a read when it targets the same non-zero register.
    function automatic logic bypass_hit(input logic     we,
                                        input reg_idx_t wb_rd,
                                        input reg_idx_t rd_idx);
        return we && (wb_rd != REG_ZERO) && (wb_rd == rd_idx);
    endfunction

endpackage

// File: rtl/operand_fetch_if.sv
// Bundle of handshake, register-file and writeback signals around the operand-fetch stage.
// OPERAND_FETCH_PERF_EN adds the two performance counter outputs.
interface operand_fetch_if;
    import soc_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [XLEN-1:0]   in_pc;
    reg_idx_t          in_rs1;
    reg_idx_t          in_rs2;
    reg_idx_t          in_rd;
    logic [XLEN-1:0]   in_imm;
    logic [CTRL_W-1:0] in_ctrl;

    reg_idx_t          rf_rs1;
    reg_idx_t          rf_rs2;
    logic [XLEN-1:0]   rf_data1;
    logic [XLEN-1:0]   rf_data2;

    logic              wb_we;
    reg_idx_t          wb_rd;
    logic [XLEN-1:0]   wb_data;
    logic              flush;

    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   out_pc;
    reg_idx_t          out_rd;
    logic [XLEN-1:0]   out_imm;
    logic [CTRL_W-1:0] out_ctrl;
    logic [XLEN-1:0]   out_rs1_val;
    logic [XLEN-1:0]   out_rs2_val;

`ifdef OPERAND_FETCH_PERF_EN
    logic [PERF_W-1:0] perf_stall_cnt;
    logic [PERF_W-1:0] perf_byp_cnt;
`endif

    modport slave (
        input  in_valid, in_pc, in_rs1, in_rs2, in_rd, in_imm, in_ctrl,
        input  rf_data1, rf_data2, wb_we, wb_rd, wb_data, flush, out_ready,
        output in_ready, rf_rs1, rf_rs2,
        output out_valid, out_pc, out_rd, out_imm, out_ctrl, out_rs1_val, out_rs2_val
`ifdef OPERAND_FETCH_PERF_EN
        , output perf_stall_cnt, perf_byp_cnt
`endif
    );

    modport master (
        output in_valid, in_pc, in_rs1, in_rs2, in_rd, in_imm, in_ctrl,
        output rf_data1, rf_data2, wb_we, wb_rd, wb_data, flush, out_ready,
        input  in_ready, rf_rs1, rf_rs2,
        input  out_valid, out_pc, out_rd, out_imm, out_ctrl, out_rs1_val, out_rs2_val
`ifdef OPERAND_FETCH_PERF_EN
        , input perf_stall_cnt, perf_byp_cnt
`endif
    );

endinterface

// File: rtl/opfetch_bypass.sv
// Per-operand writeback bypass: remembers a write that the file's read on the same edge
// missed, forces register 0 to zero and selects the final operand value.
module opfetch_bypass
    import soc_pkg::*;
(
    input  logic            clk,
    input  logic            resetn,
    input  reg_idx_t        rd_idx_i,
    input  reg_idx_t        held_idx_i,
    input  logic            wb_we_i,
    input  reg_idx_t        wb_rd_i,
    input  logic [XLEN-1:0] wb_data_i,
    input  logic [XLEN-1:0] rf_data_i,
    output logic            byp_v_o,
    output logic [XLEN-1:0] operand_o
);

    logic            byp_hit_q, byp_hit_d;
    logic [XLEN-1:0] byp_data_q, byp_data_d;

    // Re-evaluated every edge against whatever index the file is reading this cycle.
    always_comb begin
        byp_hit_d  = bypass_hit(wb_we_i, wb_rd_i, rd_idx_i);
        byp_data_d = wb_data_i;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            byp_hit_q  <= 1'b0;
            byp_data_q <= '0;
        end else begin
            byp_hit_q  <= byp_hit_d;
            byp_data_q <= byp_data_d;
        end
    end

    always_comb begin
        operand_o = rf_data_i;
        if (held_idx_i == REG_ZERO) begin
            operand_o = '0;
        end else if (byp_hit_q) begin
            operand_o = byp_data_q;
        end
    end

    assign byp_v_o = byp_hit_q;

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch stage in front of the synchronous-read register file: one-entry holding
// register, read-index steering and writeback bypass. OPERAND_FETCH_PERF_EN adds counters.
module operand_fetch
    import soc_pkg::*;
(
    input  logic           clk,
    input  logic           resetn,
    operand_fetch_if.slave opf
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    state_e       state_q, state_d;
    fetch_instr_t held_q, held_d;
    fetch_instr_t incoming_c;
    logic         in_ready_c;
    logic         accept_c;
    logic         xfer_c;
    reg_idx_t     rf_rs1_c, rf_rs2_c;
    logic         byp1_v, byp2_v;

    always_comb begin
        incoming_c      = '0;
        incoming_c.pc   = opf.in_pc;
        incoming_c.imm  = opf.in_imm;
        incoming_c.ctrl = opf.in_ctrl;
        incoming_c.rd   = opf.in_rd;
        incoming_c.rs1  = opf.in_rs1;
        incoming_c.rs2  = opf.in_rs2;
    end

    // Handshake and holding-register control; flush wins over any accept or transfer.
    always_comb begin
        state_d    = state_q;
        held_d     = held_q;
        in_ready_c = (state_q == ST_EMPTY) || opf.out_ready;
        accept_c   = opf.in_valid && in_ready_c;
        xfer_c     = (state_q == ST_FULL) && opf.out_ready;
        case (state_q)
            ST_EMPTY: if (accept_c)             state_d = ST_FULL;
            ST_FULL:  if (xfer_c && !accept_c)  state_d = ST_EMPTY;
            default:                            state_d = ST_EMPTY;
        endcase
        if (accept_c) begin
            held_d = incoming_c;
        end
        if (opf.flush) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_EMPTY;
            held_q  <= '0;
        end else begin
            state_q <= state_d;
            held_q  <= held_d;
        end
    end

    // Stalled instructions keep re-reading their own sources so the file tracks commits.
    always_comb begin
        rf_rs1_c = held_q.rs1;
        rf_rs2_c = held_q.rs2;
        if (accept_c) begin
            rf_rs1_c = opf.in_rs1;
            rf_rs2_c = opf.in_rs2;
        end
    end

    opfetch_bypass u_byp1 (
        .clk       (clk),
        .resetn    (resetn),
        .rd_idx_i  (rf_rs1_c),
        .held_idx_i(held_q.rs1),
        .wb_we_i   (opf.wb_we),
        .wb_rd_i   (opf.wb_rd),
        .wb_data_i (opf.wb_data),
        .rf_data_i (opf.rf_data1),
        .byp_v_o   (byp1_v),
        .operand_o (opf.out_rs1_val)
    );

    opfetch_bypass u_byp2 (
        .clk       (clk),
        .resetn    (resetn),
        .rd_idx_i  (rf_rs2_c),
        .held_idx_i(held_q.rs2),
        .wb_we_i   (opf.wb_we),
        .wb_rd_i   (opf.wb_rd),
        .wb_data_i (opf.wb_data),
        .rf_data_i (opf.rf_data2),
        .byp_v_o   (byp2_v),
        .operand_o (opf.out_rs2_val)
    );

    assign opf.in_ready  = in_ready_c;
    assign opf.rf_rs1    = rf_rs1_c;
    assign opf.rf_rs2    = rf_rs2_c;
    assign opf.out_valid = (state_q == ST_FULL);
    assign opf.out_pc    = held_q.pc;
    assign opf.out_rd    = held_q.rd;
    assign opf.out_imm   = held_q.imm;
    assign opf.out_ctrl  = held_q.ctrl;

`ifdef OPERAND_FETCH_PERF_EN
    logic [PERF_W-1:0] perf_stall_q, perf_stall_d;
    logic [PERF_W-1:0] perf_byp_q, perf_byp_d;

    // Free-running, wrapping counters; flush does not touch them.
    always_comb begin
        perf_stall_d = perf_stall_q;
        perf_byp_d   = perf_byp_q;
        if ((state_q == ST_FULL) && !opf.out_ready) begin
            perf_stall_d = perf_stall_q + PERF_W'(1);
        end
        if (xfer_c && (byp1_v || byp2_v)) begin
            perf_byp_d = perf_byp_q + PERF_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_stall_q <= '0;
            perf_byp_q   <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_byp_q   <= perf_byp_d;
        end
    end

    assign opf.perf_stall_cnt = perf_stall_q;
    assign opf.perf_byp_cnt   = perf_byp_q;
`else
    logic unused_byp_flags;
    assign unused_byp_flags = byp1_v ^ byp2_v;
`endif

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: directed scenarios plus randomized traffic checked
// against an architectural register/handshake model. Honours OPERAND_FETCH_PERF_EN.
module tb_operand_fetch;

    logic clk = 1'b0;
    logic resetn;
    int   errors = 0;
    int   checks = 0;

    operand_fetch_if opf ();

    operand_fetch dut (
        .clk   (clk),
        .resetn(resetn),
        .opf   (opf)
    );

    always #5 clk = ~clk;

    // Register file: registered read returning the old value on a same-edge write.
    // It deliberately stores writes to x0 too, so the stage must hide that.
    logic [63:0] regs [32] = '{default: '0};
    always @(posedge clk) begin
        opf.rf_data1 <= regs[opf.rf_rs1];
        opf.rf_data2 <= regs[opf.rf_rs2];
        if (opf.wb_we) regs[opf.wb_rd] <= opf.wb_data;
    end

    // Architectural value of a register as seen by an instruction right now.
    function automatic logic [63:0] arch(input logic [4:0] idx);
        return (idx == 5'd0) ? 64'd0 : regs[idx];
    endfunction

    // Reference model: at most one instruction in flight.
    logic        m_valid;
    logic [63:0] m_pc, m_imm;
    logic [15:0] m_ctrl;
    logic [4:0]  m_rd, m_rs1, m_rs2;
`ifdef OPERAND_FETCH_PERF_EN
    logic [31:0] m_stall, m_byp;
    logic        l_we;
    logic [4:0]  l_rd;
`endif

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_valid <= 1'b0;
            m_pc <= '0; m_imm <= '0; m_ctrl <= '0; m_rd <= '0; m_rs1 <= '0; m_rs2 <= '0;
`ifdef OPERAND_FETCH_PERF_EN
            m_stall <= '0; m_byp <= '0; l_we <= 1'b0; l_rd <= '0;
`endif
        end else begin
            if (opf.in_valid && (!m_valid || opf.out_ready)) begin
                m_valid <= 1'b1;
                m_pc <= opf.in_pc; m_imm <= opf.in_imm; m_ctrl <= opf.in_ctrl;
                m_rd <= opf.in_rd; m_rs1 <= opf.in_rs1; m_rs2 <= opf.in_rs2;
            end else if (opf.out_ready) begin
                m_valid <= 1'b0;
            end
            if (opf.flush) m_valid <= 1'b0;
`ifdef OPERAND_FETCH_PERF_EN
            if (m_valid && !opf.out_ready) m_stall <= m_stall + 32'd1;
            if (m_valid && opf.out_ready && l_we && (l_rd != 5'd0) && ((l_rd == m_rs1) || (l_rd == m_rs2)))
                m_byp <= m_byp + 32'd1;
            l_we <= opf.wb_we;
            l_rd <= opf.wb_rd;
`endif
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        opf.in_valid = 1'b0; opf.wb_we = 1'b0; opf.flush = 1'b0; opf.out_ready = 1'b1;
    endtask

    task automatic put(input logic [63:0] pc, input logic [4:0] rs1, input logic [4:0] rs2);
        opf.in_valid = 1'b1; opf.in_pc = pc; opf.in_rs1 = rs1; opf.in_rs2 = rs2;
        opf.in_rd = 5'(pc[8:4]); opf.in_imm = ~pc; opf.in_ctrl = pc[15:0] ^ 16'hA5A5;
    endtask

    task automatic wb(input logic [4:0] rd, input logic [63:0] d);
        opf.wb_we = 1'b1; opf.wb_rd = rd; opf.wb_data = d;
    endtask

    task automatic test_reset();
        idle();
        put(64'h0, 5'd0, 5'd0);
        opf.in_valid = 1'b0; opf.wb_rd = '0; opf.wb_data = '0;
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (opf.out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0h want 0", opf.out_valid); end
        checks++; if (opf.in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %0h want 1", opf.in_ready); end
        checks++; if (opf.rf_rs1 !== 5'd0) begin errors++; $display("FAIL rst_rf_rs1: got %0h want 0", opf.rf_rs1); end
        checks++; if (opf.rf_rs2 !== 5'd0) begin errors++; $display("FAIL rst_rf_rs2: got %0h want 0", opf.rf_rs2); end
        checks++; if (opf.out_pc !== 64'd0) begin errors++; $display("FAIL rst_pc: got %0h want 0", opf.out_pc); end
        checks++; if (opf.out_rs1_val !== 64'd0) begin errors++; $display("FAIL rst_rs1_val: got %0h want 0", opf.out_rs1_val); end
        @(posedge clk);
        #1 resetn = 1'b1;
    endtask

    task automatic test_basic();
        nxt(); idle(); wb(5'd1, 64'h11);
        nxt(); idle(); put(64'h100, 5'd1, 5'd0);
        @(negedge clk);
        checks++; if (opf.in_ready !== 1'b1) begin errors++; $display("FAIL basic_ready0: got %0h want 1", opf.in_ready); end
        checks++; if (opf.rf_rs1 !== 5'd1) begin errors++; $display("FAIL basic_rf_rs1: got %0h want 1", opf.rf_rs1); end
        nxt(); idle();
        @(negedge clk);
        checks++; if (opf.out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %0h want 1", opf.out_valid); end
        checks++; if (opf.out_rs1_val !== 64'h11) begin errors++; $display("FAIL basic_rs1: got %0h want 11", opf.out_rs1_val); end
        checks++; if (opf.out_rs2_val !== 64'h0) begin errors++; $display("FAIL basic_rs2: got %0h want 0", opf.out_rs2_val); end
        checks++; if (opf.out_pc !== 64'h100) begin errors++; $display("FAIL basic_pc: got %0h want 100", opf.out_pc); end
        checks++; if (opf.in_ready !== 1'b1) begin errors++; $display("FAIL basic_ready1: got %0h want 1", opf.in_ready); end
    endtask

    task automatic test_bypass_accept();
        nxt(); idle(); put(64'h200, 5'd5, 5'd0); wb(5'd5, 64'hDEAD);
        @(negedge clk);
        checks++; if (opf.rf_rs1 !== 5'd5) begin errors++; $display("FAIL byp_rf_rs1: got %0h want 5", opf.rf_rs1); end
        nxt(); idle();
        @(negedge clk);
        checks++; if (opf.out_valid !== 1'b1) begin errors++; $display("FAIL byp_valid: got %0h want 1", opf.out_valid); end
        checks++; if (opf.out_rs1_val !== 64'hDEAD) begin errors++; $display("FAIL byp_rs1: got %0h want dead", opf.out_rs1_val); end
    endtask

    task automatic test_stall_commit();
        nxt(); idle(); put(64'h300, 5'd0, 5'd7);
        nxt(); idle(); opf.out_ready = 1'b0; put(64'h3F0, 5'd7, 5'd7);
        for (int s = 1; s <= 3; s++) begin
            if (s == 2) wb(5'd7, 64'h77);
            if (s == 3) opf.wb_we = 1'b0;
            @(negedge clk);
            checks++; if (opf.in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready%0d: got %0h want 0", s, opf.in_ready); end
            checks++; if (opf.out_pc !== 64'h300) begin errors++; $display("FAIL stall_pc%0d: got %0h want 300", s, opf.out_pc); end
            checks++; if (opf.out_imm !== ~64'h300) begin errors++; $display("FAIL stall_imm%0d: got %0h want %0h", s, opf.out_imm, ~64'h300); end
            checks++; if (opf.out_ctrl !== (16'h0300 ^ 16'hA5A5)) begin errors++; $display("FAIL stall_ctrl%0d: got %0h want %0h", s, opf.out_ctrl, 16'h0300 ^ 16'hA5A5); end
            checks++; if (opf.out_rs2_val !== ((s == 3) ? 64'h77 : 64'h0)) begin errors++; $display("FAIL stall_rs2_%0d: got %0h want %0h", s, opf.out_rs2_val, (s == 3) ? 64'h77 : 64'h0); end
            nxt();
        end
        opf.in_valid = 1'b0; opf.out_ready = 1'b1;
        @(negedge clk);
        checks++; if (opf.out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid_end: got %0h want 1", opf.out_valid); end
        checks++; if (opf.out_rs2_val !== 64'h77) begin errors++; $display("FAIL stall_rs2_reread: got %0h want 77", opf.out_rs2_val); end
    endtask

    task automatic test_x0();
        nxt(); idle(); put(64'h400, 5'd0, 5'd0); wb(5'd0, 64'hFF);
        @(negedge clk);
        checks++; if (opf.rf_rs1 !== 5'd0) begin errors++; $display("FAIL x0_rf_rs1: got %0h want 0", opf.rf_rs1); end
        nxt(); idle(); put(64'h410, 5'd0, 5'd1);
        @(negedge clk);
        checks++; if (opf.out_rs1_val !== 64'd0) begin errors++; $display("FAIL x0_wb_rs1: got %0h want 0", opf.out_rs1_val); end
        nxt(); idle();
        @(negedge clk);
        checks++; if (opf.out_valid !== 1'b1) begin errors++; $display("FAIL x0_b2b_valid: got %0h want 1", opf.out_valid); end
        checks++; if (opf.out_pc !== 64'h410) begin errors++; $display("FAIL x0_b2b_pc: got %0h want 410", opf.out_pc); end
        checks++; if (opf.out_rs1_val !== 64'd0) begin errors++; $display("FAIL x0_file_rs1: got %0h want 0", opf.out_rs1_val); end
        checks++; if (opf.out_rs2_val !== 64'h11) begin errors++; $display("FAIL x0_rs2: got %0h want 11", opf.out_rs2_val); end
    endtask

    task automatic test_flush();
        logic [63:0] pc;
        for (int i = 0; i < 4; i++) begin
            nxt(); idle();
            pc = 64'h500 + 64'(16 * i);
            put(pc, 5'(i + 1), 5'(i + 2));
            if (i == 2) opf.flush = 1'b1;
            if (i == 3) wb(5'd4, 64'h4444);
            @(negedge clk);
            if (i == 1 || i == 2) begin
                checks++; if (opf.out_valid !== 1'b1) begin errors++; $display("FAIL flush_valid%0d: got %0h want 1", i, opf.out_valid); end
                checks++; if (opf.out_pc !== pc - 64'h10) begin errors++; $display("FAIL flush_pc%0d: got %0h want %0h", i, opf.out_pc, pc - 64'h10); end
            end
            if (i == 3) begin
                checks++; if (opf.out_valid !== 1'b0) begin errors++; $display("FAIL flush_killed: got %0h want 0", opf.out_valid); end
                checks++; if (opf.in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready: got %0h want 1", opf.in_ready); end
            end
        end
        nxt(); idle();
        @(negedge clk);
        checks++; if (opf.out_valid !== 1'b1) begin errors++; $display("FAIL flush4_valid: got %0h want 1", opf.out_valid); end
        checks++; if (opf.out_pc !== 64'h530) begin errors++; $display("FAIL flush4_pc: got %0h want 530", opf.out_pc); end
        checks++; if (opf.out_rs1_val !== 64'h4444) begin errors++; $display("FAIL flush4_rs1: got %0h want 4444", opf.out_rs1_val); end
        checks++; if (opf.out_rs2_val !== arch(5'd5)) begin errors++; $display("FAIL flush4_rs2: got %0h want %0h", opf.out_rs2_val, arch(5'd5)); end
    endtask

    task automatic test_random();
        logic exp_rdy;
        for (int c = 0; c < 600; c++) begin
            nxt();
            opf.in_valid  = ($urandom_range(0, 9) < 7);
            opf.in_pc     = {$urandom, $urandom};
            opf.in_rs1    = 5'($urandom_range(0, 7));
            opf.in_rs2    = 5'($urandom_range(0, 7));
            opf.in_rd     = 5'($urandom_range(0, 31));
            opf.in_imm    = {$urandom, $urandom};
            opf.in_ctrl   = 16'($urandom);
            opf.out_ready = ($urandom_range(0, 9) < 6);
            opf.wb_we     = 1'($urandom_range(0, 1));
            opf.wb_rd     = 5'($urandom_range(0, 7));
            opf.wb_data   = {$urandom, $urandom};
            opf.flush     = ($urandom_range(0, 15) == 0);
            @(negedge clk);
            exp_rdy = !m_valid || opf.out_ready;
            checks++; if (opf.in_ready !== exp_rdy) begin errors++; $display("FAIL rnd_ready c%0d: got %0h want %0h", c, opf.in_ready, exp_rdy); end
            checks++; if (opf.out_valid !== m_valid) begin errors++; $display("FAIL rnd_valid c%0d: got %0h want %0h", c, opf.out_valid, m_valid); end
            if (opf.in_valid && exp_rdy) begin
                checks++; if ({opf.rf_rs1, opf.rf_rs2} !== {opf.in_rs1, opf.in_rs2}) begin errors++; $display("FAIL rnd_rf_new c%0d: got %0h want %0h", c, {opf.rf_rs1, opf.rf_rs2}, {opf.in_rs1, opf.in_rs2}); end
            end else if (m_valid) begin
                checks++; if ({opf.rf_rs1, opf.rf_rs2} !== {m_rs1, m_rs2}) begin errors++; $display("FAIL rnd_rf_held c%0d: got %0h want %0h", c, {opf.rf_rs1, opf.rf_rs2}, {m_rs1, m_rs2}); end
            end
            if (m_valid) begin
                checks++; if (opf.out_pc !== m_pc) begin errors++; $display("FAIL rnd_pc c%0d: got %0h want %0h", c, opf.out_pc, m_pc); end
                checks++; if (opf.out_imm !== m_imm) begin errors++; $display("FAIL rnd_imm c%0d: got %0h want %0h", c, opf.out_imm, m_imm); end
                checks++; if ({opf.out_ctrl, opf.out_rd} !== {m_ctrl, m_rd}) begin errors++; $display("FAIL rnd_ctrl_rd c%0d: got %0h want %0h", c, {opf.out_ctrl, opf.out_rd}, {m_ctrl, m_rd}); end
                checks++; if (opf.out_rs1_val !== arch(m_rs1)) begin errors++; $display("FAIL rnd_rs1 c%0d: got %0h want %0h", c, opf.out_rs1_val, arch(m_rs1)); end
                checks++; if (opf.out_rs2_val !== arch(m_rs2)) begin errors++; $display("FAIL rnd_rs2 c%0d: got %0h want %0h", c, opf.out_rs2_val, arch(m_rs2)); end
            end
        end
`ifdef OPERAND_FETCH_PERF_EN
        checks++; if (opf.perf_stall_cnt !== m_stall) begin errors++; $display("FAIL perf_stall: got %0d want %0d", opf.perf_stall_cnt, m_stall); end
        checks++; if (opf.perf_byp_cnt !== m_byp) begin errors++; $display("FAIL perf_byp: got %0d want %0d", opf.perf_byp_cnt, m_byp); end
`endif
    endtask

    task automatic test_async_reset();
        nxt(); idle(); opf.out_ready = 1'b0; put(64'h600, 5'd3, 5'd4);
        nxt(); opf.in_valid = 1'b0;
        checks++; if (opf.out_valid !== 1'b1) begin errors++; $display("FAIL arst_pre_valid: got %0h want 1", opf.out_valid); end
        #2 resetn = 1'b0;
        #1;
        checks++; if (opf.out_valid !== 1'b0) begin errors++; $display("FAIL arst_valid: got %0h want 0", opf.out_valid); end
        checks++; if (opf.rf_rs1 !== 5'd0) begin errors++; $display("FAIL arst_rf_rs1: got %0h want 0", opf.rf_rs1); end
`ifdef OPERAND_FETCH_PERF_EN
        checks++; if (opf.perf_stall_cnt !== 32'd0) begin errors++; $display("FAIL arst_perf_stall: got %0d want 0", opf.perf_stall_cnt); end
        checks++; if (opf.perf_byp_cnt !== 32'd0) begin errors++; $display("FAIL arst_perf_byp: got %0d want 0", opf.perf_byp_cnt); end
`endif
        @(posedge clk);
        #1 resetn = 1'b1;
        nxt();
        @(negedge clk);
        checks++; if (opf.out_valid !== 1'b0) begin errors++; $display("FAIL arst_after: got %0h want 0", opf.out_valid); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bypass_accept();
        test_stall_commit();
        test_x0();
        test_flush();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
